multicycle_sequencer: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle processor top's control.
- FSM sequences the existing DataPath through FETCH/DECODE/EXECUTE/MEM/WB, one instruction per 3–5+ cycles.
- Adds valid/ready handshakes to instruction and data memory (variable latency), a timeout watchdog and a fault halt.
- Sits beside ControlPath: ControlPath still decodes the control fields; this block gates when they take effect (ir_en, pc_en, reg_wr_gate, dmem_req).

---
 rtl/multicycle_sequencer_pkg.sv | 66 ++++++
 rtl/multicycle_sequencer_if.sv | 29 ++
 rtl/multicycle_sequencer_watchdog.sv | 33 +++
 rtl/multicycle_sequencer.sv | 154 +++++++++++++++
 tb/tb_multicycle_sequencer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// Shared types and constants for the multi-cycle sequencer: state, fault and
// instruction-class encodings plus the opcode classifier.
package multicycle_sequencer_pkg;

    localparam int BUS_WIDTH = 32;
    localparam int OPC_W     = 7;
    localparam int STATE_W   = 3;
    localparam int FAULT_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_HALT    = 3'd5
    } state_e;

    typedef enum logic [FAULT_W-1:0] {
        FLT_NONE     = 2'b00,
        FLT_ILLEGAL  = 2'b01,
        FLT_IMEM_TMO = 2'b10,
        FLT_DMEM_TMO = 2'b11
    } fault_e;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_UPPER
    } iclass_e;

    localparam logic [OPC_W-1:0] OPC_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_I      = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic    legal;
        iclass_e cls;
    } decode_t;

    function automatic decode_t classify(input logic [OPC_W-1:0] opc);
        decode_t d;
        d.legal = 1'b1;
        d.cls   = CLS_ALU;
        case (opc)
            OPC_R, OPC_I:       d.cls = CLS_ALU;
            OPC_LOAD:           d.cls = CLS_LOAD;
            OPC_STORE:          d.cls = CLS_STORE;
            OPC_BRANCH:         d.cls = CLS_BRANCH;
            OPC_JAL, OPC_JALR:  d.cls = CLS_JUMP;
            OPC_LUI, OPC_AUIPC: d.cls = CLS_UPPER;
            default:            d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Sequencer control bundle: opcode and memory ready inputs, gating strobes and status.
interface multicycle_sequencer_if;
    import multicycle_sequencer_pkg::*;

    logic [OPC_W-1:0]   opcode;
    logic               imem_ready;
    logic               dmem_ready;
    logic               imem_req;
    logic               ir_en;
    logic               dmem_req;
    logic               dmem_we;
    logic               reg_wr_gate;
    logic               pc_en;
    logic [STATE_W-1:0] state_o;
    logic [FAULT_W-1:0] fault;
    logic               halted;

    modport master (
        input  opcode, imem_ready, dmem_ready,
        output imem_req, ir_en, dmem_req, dmem_we, reg_wr_gate, pc_en,
               state_o, fault, halted
    );

    modport slave (
        output opcode, imem_ready, dmem_ready,
        input  imem_req, ir_en, dmem_req, dmem_we, reg_wr_gate, pc_en,
               state_o, fault, halted
    );
endinterface

// File: rtl/multicycle_sequencer_watchdog.sv
// mc_watchdog: saturating wait-cycle counter; o_expired flags the LIMIT-th
// consecutive enabled cycle (LIMIT=0 disables it).
module mc_watchdog #(
    parameter int unsigned W     = 8,
    parameter int unsigned LIMIT = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The count holds the waits already taken, so the terminal cycle is LIMIT-1.
    if (LIMIT == 0) begin : g_off
        assign o_expired = 1'b0;
    end else begin : g_on
        assign o_expired = i_en && (r_cnt >= W'(LIMIT - 1));
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer with memory handshakes,
// wait-state watchdog and sticky fault halt. Optional MC_PERF_CNT_EN adds perf counters.
module multicycle_sequencer #(
    parameter int unsigned BUS_WIDTH   = multicycle_sequencer_pkg::BUS_WIDTH,
    parameter int unsigned TMO_W       = 8,
    parameter int unsigned MEM_TIMEOUT = 200
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_sequencer_if.master  bus
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0]             cycle_cnt,
    output logic [31:0]             instret_cnt
`endif
);
    import multicycle_sequencer_pkg::*;

    if (MEM_TIMEOUT >= (2 ** TMO_W) - 1) begin : g_tmo_chk
        $error("MEM_TIMEOUT must be below the watchdog saturation value");
    end
    if (BUS_WIDTH < OPC_W) begin : g_bus_chk
        $error("BUS_WIDTH too narrow to carry the opcode field");
    end

    state_e  r_state, w_state_nxt;
    iclass_e r_cls, w_cls_nxt;
    fault_e  r_fault, w_fault_nxt;
    decode_t w_dec;

    logic w_imem_req, w_ir_en, w_dmem_req, w_dmem_we, w_reg_wr_gate, w_pc_en;
    logic w_wd_en, w_wd_expired;

    assign w_dec   = classify(bus.opcode);
    // Waiting means staying put; any other cycle is a state change and clears the count.
    assign w_wd_en = ((r_state == ST_FETCH) && !bus.imem_ready) ||
                     ((r_state == ST_MEM)   && !bus.dmem_ready);

    mc_watchdog #(
        .W     (TMO_W),
        .LIMIT (MEM_TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (!w_wd_en),
        .i_en      (w_wd_en),
        .o_expired (w_wd_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_FETCH;
            r_cls   <= CLS_ALU;
            r_fault <= FLT_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_cls   <= w_cls_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cls_nxt     = r_cls;
        w_fault_nxt   = r_fault;
        w_imem_req    = 1'b0;
        w_ir_en       = 1'b0;
        w_dmem_req    = 1'b0;
        w_dmem_we     = 1'b0;
        w_reg_wr_gate = 1'b0;
        w_pc_en       = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_imem_req = 1'b1;
                if (bus.imem_ready) begin
                    w_ir_en     = 1'b1;
                    w_state_nxt = ST_DECODE;
                end else if (w_wd_expired) begin
                    w_state_nxt = ST_HALT;
                    w_fault_nxt = FLT_IMEM_TMO;
                end
            end
            ST_DECODE: begin
                if (w_dec.legal) begin
                    w_cls_nxt   = w_dec.cls;
                    w_state_nxt = ST_EXECUTE;
                end else begin
                    w_state_nxt = ST_HALT;
                    w_fault_nxt = FLT_ILLEGAL;
                end
            end
            ST_EXECUTE: begin
                case (r_cls)
                    CLS_BRANCH: begin
                        w_pc_en     = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: w_state_nxt = ST_MEM;
                    default:             w_state_nxt = ST_WB;
                endcase
            end
            ST_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = (r_cls == CLS_STORE);
                if (bus.dmem_ready) begin
                    if (r_cls == CLS_STORE) begin
                        w_pc_en     = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_state_nxt = ST_WB;
                    end
                end else if (w_wd_expired) begin
                    w_state_nxt = ST_HALT;
                    w_fault_nxt = FLT_DMEM_TMO;
                end
            end
            ST_WB: begin
                w_reg_wr_gate = 1'b1;
                w_pc_en       = 1'b1;
                w_state_nxt   = ST_FETCH;
            end
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_FETCH;
        endcase
    end

    assign bus.imem_req    = w_imem_req;
    assign bus.ir_en       = w_ir_en;
    assign bus.dmem_req    = w_dmem_req;
    assign bus.dmem_we     = w_dmem_we;
    assign bus.reg_wr_gate = w_reg_wr_gate;
    assign bus.pc_en       = w_pc_en;
    assign bus.state_o     = r_state;
    assign bus.fault       = r_fault;
    assign bus.halted      = (r_state == ST_HALT);

`ifdef MC_PERF_CNT_EN
    logic [31:0] r_cycle_cnt, r_instret_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (r_state != ST_HALT) r_cycle_cnt   <= r_cycle_cnt + 32'd1;
            if (w_pc_en)            r_instret_cnt <= r_instret_cnt + 32'd1;
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: per-instruction vector table with a result
// scoreboard, plus hand sequences for illegal-opcode halt and mid-MEM reset.
module tb_multicycle_sequencer;
    import multicycle_sequencer_pkg::*;

    logic clk;
    logic rst;
    multicycle_sequencer_if bus();
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    multicycle_sequencer #(
        .TMO_W       (8),
        .MEM_TIMEOUT (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  opc;
        bit          tie;
        int unsigned iw;
        int unsigned dw;
        int unsigned cyc;
        int unsigned rwg;
        int unsigned dreq;
        logic        we;
        logic [1:0]  flt;
        logic [31:0] trace;
    } vec_t;

    typedef struct {
        int unsigned cyc;
        int unsigned rwg;
        int unsigned dreq;
        int unsigned ret;
        int unsigned ire;
        logic        we;
        logic [1:0]  flt;
        logic [31:0] trace;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [6:0] opc, input bit tie, input int unsigned iw,
                       input int unsigned dw, input int unsigned cyc, input int unsigned rwg,
                       input int unsigned dreq, input logic we, input logic [1:0] flt,
                       input logic [31:0] trace);
        vec_t v;
        v = '{opc:opc, tie:tie, iw:iw, dw:dw, cyc:cyc, rwg:rwg, dreq:dreq,
              we:we, flt:flt, trace:trace};
        vt.push_back(v);
    endtask

    // Ends at posedge+1 of the first FETCH cycle after reset release.
    task automatic do_reset();
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.opcode     = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Called at posedge+1 of an instruction's first FETCH cycle.
    task automatic exec(input vec_t v, input int idx);
        exp_t e, got;
        logic [2:0] st;
        logic [6:0] alt;
        int unsigned fcnt, mcnt;
        bit done;
`ifdef MC_PERF_CNT_EN
        logic [31:0] ir0;
        ir0 = instret_cnt;
`endif
        e = '{cyc:v.cyc, rwg:v.rwg, dreq:v.dreq, ret:(v.flt == 2'b00) ? 1 : 0,
              ire:(v.flt == 2'b10) ? 0 : 1, we:v.we, flt:v.flt, trace:v.trace};
        sb.push_back(e);
        got = '{cyc:0, rwg:0, dreq:0, ret:0, ire:0, we:1'b0, flt:2'b00, trace:'0};
        alt  = (v.opc == 7'h63) ? 7'h23 : 7'h63;
        fcnt = 0;
        mcnt = 0;
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            st = bus.state_o;
            if (bus.halted) begin
                done = 1'b1;
            end else begin
                bus.opcode = (st == 3'd0 || st == 3'd1) ? v.opc : alt;
                if (v.tie) begin
                    bus.imem_ready = 1'b1;
                    bus.dmem_ready = 1'b1;
                end else begin
                    bus.imem_ready = (st == 3'd0) && (fcnt >= v.iw);
                    bus.dmem_ready = (st == 3'd3) && (mcnt >= v.dw);
                end
                if (st == 3'd0) fcnt++;
                if (st == 3'd3) mcnt++;
                #1;
                got.cyc++;
                got.trace = {got.trace[27:0], 1'b0, st};
                if (bus.ir_en)       got.ire++;
                if (bus.reg_wr_gate) got.rwg++;
                if (bus.dmem_req) begin
                    got.dreq++;
                    got.we = got.we | bus.dmem_we;
                end
                if (bus.pc_en) begin
                    got.ret++;
                    done = 1'b1;
                end
                @(posedge clk);
                #1;
            end
        end
        got.flt = bus.fault;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL row%0d_timeout: no retire or halt within 40 cycles", idx);
        end
        e = sb.pop_front();
        chk($sformatf("row%0d_cycles", idx), got.cyc, e.cyc);
        chk($sformatf("row%0d_trace", idx), got.trace, e.trace);
        chk($sformatf("row%0d_pc_en", idx), got.ret, e.ret);
        chk($sformatf("row%0d_ir_en", idx), got.ire, e.ire);
        chk($sformatf("row%0d_reg_wr_gate", idx), got.rwg, e.rwg);
        chk($sformatf("row%0d_dmem_req", idx), got.dreq, e.dreq);
        chk($sformatf("row%0d_dmem_we", idx), {31'd0, got.we}, {31'd0, e.we});
        chk($sformatf("row%0d_fault", idx), {30'd0, got.flt}, {30'd0, e.flt});
        chk($sformatf("row%0d_halted", idx), {31'd0, bus.halted}, (e.flt != 2'b00) ? 1 : 0);
`ifdef MC_PERF_CNT_EN
        chk($sformatf("row%0d_instret", idx), instret_cnt - ir0, e.ret);
`endif
    endtask

    initial begin
        int unsigned mc;
        int unsigned pulses;
        bit hit;

        // opcode, tie, iwait, dwait | cycles, reg_wr, dmem_req cycles, we, fault, state trace
        add(7'h33, 1, 0, 0,  4, 1, 0, 1'b0, 2'b00, 32'h0124);
        add(7'h03, 0, 0, 3,  8, 1, 4, 1'b0, 2'b00, 32'h01233334);
        add(7'h23, 0, 0, 0,  4, 0, 1, 1'b1, 2'b00, 32'h0123);
        add(7'h63, 0, 0, 0,  3, 0, 0, 1'b0, 2'b00, 32'h012);
        add(7'h13, 0, 2, 0,  6, 1, 0, 1'b0, 2'b00, 32'h000124);
        add(7'h37, 1, 0, 0,  4, 1, 0, 1'b0, 2'b00, 32'h0124);
        add(7'h17, 0, 0, 0,  4, 1, 0, 1'b0, 2'b00, 32'h0124);
        add(7'h6F, 0, 1, 0,  5, 1, 0, 1'b0, 2'b00, 32'h00124);
        add(7'h67, 0, 0, 0,  4, 1, 0, 1'b0, 2'b00, 32'h0124);
        add(7'h23, 0, 0, 2,  6, 0, 3, 1'b1, 2'b00, 32'h012333);
        add(7'h03, 0, 0, 4,  9, 1, 5, 1'b0, 2'b00, 32'h12333334);
        add(7'h33, 0, 4, 0,  8, 1, 0, 1'b0, 2'b00, 32'h00000124);
        add(7'h33, 0, 5, 0,  5, 0, 0, 1'b0, 2'b10, 32'h0);
        add(7'h03, 0, 0, 5,  8, 0, 5, 1'b0, 2'b11, 32'h01233333);
        add(7'h23, 0, 1, 7,  9, 0, 5, 1'b1, 2'b11, 32'h01233333);

        rst = 1'b0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.opcode = '0;
        #1;
        chk("rst_state", {29'd0, bus.state_o}, 0);
        chk("rst_fault", {30'd0, bus.fault}, 0);
        chk("rst_halted", {31'd0, bus.halted}, 0);
        chk("rst_strobes", {28'd0, bus.ir_en, bus.pc_en, bus.reg_wr_gate, bus.dmem_req}, 0);

        do_reset();
        foreach (vt[i]) begin
            exec(vt[i], i);
            if (bus.halted) do_reset();
        end

        // Illegal opcode: sticky halt, spurious readys ignored, async reset recovers.
        do_reset();
        bus.opcode = 7'h7F;
        bus.imem_ready = 1'b1;
        #1 chk("ill_ir_en", {31'd0, bus.ir_en}, 1);
        @(posedge clk); #1;
        chk("ill_decode", {29'd0, bus.state_o}, 1);
        @(posedge clk); #1;
        chk("ill_state", {29'd0, bus.state_o}, 5);
        chk("ill_fault", {30'd0, bus.fault}, 1);
        chk("ill_halted", {31'd0, bus.halted}, 1);
        pulses = 0;
        for (int n = 0; n < 6; n++) begin
            bus.imem_ready = n[0];
            bus.dmem_ready = 1'b1;
            bus.opcode = 7'h33;
            #1;
            if (bus.imem_req || bus.ir_en || bus.dmem_req || bus.pc_en || bus.reg_wr_gate ||
                bus.state_o != 3'd5 || bus.fault != 2'b01)
                pulses++;
            @(posedge clk); #1;
        end
        chk("halt_sticky", pulses, 0);
        rst = 1'b0;
        #1;
        chk("ill_rst_state", {29'd0, bus.state_o}, 0);
        chk("ill_rst_fault", {30'd0, bus.fault}, 0);
        chk("ill_rst_halted", {31'd0, bus.halted}, 0);

        // Reset asserted during the MEM wait of a load.
        do_reset();
        bus.opcode = 7'h03;
        mc = 0;
        hit = 1'b0;
        for (int n = 0; n < 12 && !hit; n++) begin
            bus.imem_ready = (bus.state_o == 3'd0);
            bus.dmem_ready = 1'b0;
            if (bus.state_o == 3'd3) begin
                mc++;
                if (mc == 2) hit = 1'b1;
            end
            if (!hit) begin
                @(posedge clk); #1;
            end
        end
        chk("mid_reach_mem", {31'd0, hit}, 1);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_state", {29'd0, bus.state_o}, 0);
        chk("mid_rst_strobes", {29'd0, bus.pc_en, bus.reg_wr_gate, bus.dmem_req}, 0);
        pulses = 0;
        bus.imem_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            if (n == 2) rst = 1'b1;
            #1;
            if (bus.pc_en || bus.reg_wr_gate) pulses++;
        end
        chk("mid_rst_no_pulse", pulses, 0);
        chk("mid_rst_fetch", {29'd0, bus.state_o}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
